round_scheduler: RTL and testbench
==================================

// Module: round_scheduler
// PURPOSE
//  Shares one result_rounder between NUM_REQUESTERS un-rounded result producers (adder, multiplier, ...).
//  Round-robin arbitration, one capture stage, rounder, one output register; valid/ready on both sides.
//  Emits the rounded {sign, exponent, mantissa}, the overflow flag and the index of the winning requester.
// PARAMETERS
//  EXPONENT_WIDTH    8   exponent field width
//  MANTISSA_WIDTH    23  stored mantissa width (no hidden bit)
//  ROUND_TO_NEAREST  1   passed to result_rounder; 0 = truncate
//  ROUNDING_BITS     3   guard/round/sticky width, >= 2
//  NUM_REQUESTERS    2   number of requesters, >= 2
//  localparam SRC_WIDTH = $clog2(NUM_REQUESTERS)
// PORTS
//  clk                input   1            clock, rising edge
//  rst                input   1            synchronous, active-high reset
//  req_valid          input   N            per-requester valid
//  req_ready          output  N            per-requester grant/accept, one-hot or zero
//  req_sign           input   N            packed, requester i at bit i
//  req_exponent       input   N*E          packed, requester i at [i*E +: E]
//  req_mantissa       input   N*M          packed, requester i at [i*M +: M]
//  req_rounding_bits  input   N*R          packed, requester i at [i*R +: R]
//  out_valid          output  1            result valid
//  out_ready          input   1            downstream accept
//  out_sign           output  1            unchanged from request
//  out_exponent       output  E            rounded exponent
//  out_mantissa       output  M            rounded mantissa
//  out_overflow       output  1            rounding overflowed to infinity
//  out_source         output  SRC_WIDTH    index of the originating requester
// BEHAVIOUR
//  - Reset: all outputs 0, s1_valid = 0, RR pointer = 0; req_ready = 0 during reset.
//  - Transfer occurs on valid && ready at a clk edge; producers hold their payload stable while valid && !ready.
//  - Pipeline: S1 (captured request + source), S2 (output register). Latency is 2 cycles from accept to out_valid.
//  - advance_s2 = !out_valid || out_ready; advance_s1 = !s1_valid || advance_s2.
//  - Arbitration: combinational. When advance_s1 is high, grant the first requester with req_valid high, searching
//    from ptr, ptr+1, ... modulo N. req_ready[grant] = 1 and all other bits = 0.
//    req_ready is 0 for every requester when advance_s1 is low or no requester is valid.
//  - On grant: ptr <= grant+1 (wraps to 0 after N-1); capture payload into S1, s1_valid <= 1, s1_src <= grant.
//    When advance_s1 is high and there is no grant: s1_valid <= 0 and ptr holds.
//  - Rounder: one combinational result_rounder instance between S1 and S2.
//    Special-value bypass: if s1_exponent is all ones (Inf/NaN), pass exponent and mantissa unchanged, overflow = 0.
//  - On advance_s2: out_* <= rounder result for S1, out_valid <= s1_valid. Outputs hold while out_valid && !out_ready.
//  - Full throughput: one result per cycle when out_ready stays high and requests are always present.
//  - Backpressure: out_ready low with out_valid high stalls S2. S1 then fills and stalls, and req_ready goes to 0.
//    Nothing is dropped or duplicated.
//  - Simultaneous events: S2 drains and S1 refills in the same cycle.
//  - Reset mid-operation: all in-flight results are discarded and no out_valid is asserted afterwards for them.
//  - Overflow case: exp = all ones - 1 with mantissa all ones that rounds up gives exp = all ones,
//    mantissa = 0, out_overflow = 1.
// STRUCTURE
//  - Shared package/header: packed-field offset macros and SRC_WIDTH computation, shared with other multi-unit blocks.
//  - Sub-module rr_arbiter #(N): req[N], ptr in, grant one-hot out, grant_idx out. Reused later for divider sharing.
//  - result_rounder instantiated unmodified.
// TESTING (E=8, M=23, R=3, N=2 unless stated)
//  1. Reset: assert rst mid-stream with S1/S2 full -> next cycle out_valid=0, req_ready=0; after release, ptr=0.
//  2. Single request: r0 {s=0, exp=0x80, man=0x000001, rb=3'b100} -> 2 cycles later
//     exp=0x80, man=0x000002, overflow=0, source=0.
//  3. Round-robin: both valid every cycle, out_ready=1 -> sources alternate 0,1,0,1;
//     each requester gets one grant per 2 cycles.
//  4. Overflow: exp=0xFE, man=0x7FFFFF, rb=3'b110 -> exp=0xFF, man=0, out_overflow=1.
//     Input exp=0xFF, man=0x400000 -> passes through unchanged, overflow=0.
//  5. Backpressure: out_ready=0 for 5 cycles during a stream of 6 requests -> req_ready=0 once S1 is full,
//     out_* stable; after release, all 6 results arrive in accept order.
//  6. Truncate mode (ROUND_TO_NEAREST=0, N=3): man=0x7FFFFF, rb=3'b111 -> output unchanged; sources cycle 0,1,2.

Source files
------------

// File: rtl/round_scheduler_pkg.sv
// Shared helpers for multi-unit blocks that pack per-requester fields into flat buses.
package round_scheduler_pkg;

  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // LSB offset of field idx in a packed bus of width-wide fields
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/result_rounder.sv
// Rounds a mantissa using guard/round/sticky bits; carries into the exponent and flags overflow.
module result_rounder #(
  parameter int unsigned EXPONENT_WIDTH   = 8,
  parameter int unsigned MANTISSA_WIDTH   = 23,
  parameter int unsigned ROUND_TO_NEAREST = 1,
  parameter int unsigned ROUNDING_BITS    = 3
) (
  input  logic [EXPONENT_WIDTH-1:0] exponent,
  input  logic [MANTISSA_WIDTH-1:0] mantissa,
  input  logic [ROUNDING_BITS-1:0]  rounding_bits,
  output logic [EXPONENT_WIDTH-1:0] rounded_exponent,
  output logic [MANTISSA_WIDTH-1:0] rounded_mantissa,
  output logic                      overflow
);

  localparam int unsigned MW1     = MANTISSA_WIDTH + 1;
  localparam bit          NEAREST = (ROUND_TO_NEAREST != 0);

  logic           guard;
  logic           sticky;
  logic           round_up;
  logic [MW1-1:0] man_sum;

  // Round half to even: a pure tie only rounds up when the mantissa is odd
  assign guard    = rounding_bits[ROUNDING_BITS-1];
  assign sticky   = |rounding_bits[ROUNDING_BITS-2:0];
  assign round_up = NEAREST && guard && (sticky || mantissa[0]);

  assign man_sum          = {1'b0, mantissa} + MW1'(round_up);
  assign rounded_mantissa = man_sum[MANTISSA_WIDTH-1:0];
  assign rounded_exponent = exponent + EXPONENT_WIDTH'(man_sum[MANTISSA_WIDTH]);
  assign overflow         = man_sum[MANTISSA_WIDTH] && (&rounded_exponent);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, modulo N.
module rr_arbiter
  import round_scheduler_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_WIDTH = src_width(N)
) (
  input  logic [N-1:0]         req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < int'(N); k++) begin
      idx = (int'(ptr) + k) % int'(N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// Shares one result_rounder among several requesters: RR arbitration, capture stage, rounder, output register.
module round_scheduler
  import round_scheduler_pkg::*;
#(
  parameter int unsigned EXPONENT_WIDTH   = 8,
  parameter int unsigned MANTISSA_WIDTH   = 23,
  parameter int unsigned ROUND_TO_NEAREST = 1,
  parameter int unsigned ROUNDING_BITS    = 3,
  parameter int unsigned NUM_REQUESTERS   = 2,
  localparam int unsigned SRC_WIDTH       = src_width(NUM_REQUESTERS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQUESTERS-1:0]                req_valid,
  output logic [NUM_REQUESTERS-1:0]                req_ready,
  input  logic [NUM_REQUESTERS-1:0]                req_sign,
  input  logic [NUM_REQUESTERS*EXPONENT_WIDTH-1:0] req_exponent,
  input  logic [NUM_REQUESTERS*MANTISSA_WIDTH-1:0] req_mantissa,
  input  logic [NUM_REQUESTERS*ROUNDING_BITS-1:0]  req_rounding_bits,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_sign,
  output logic [EXPONENT_WIDTH-1:0]                out_exponent,
  output logic [MANTISSA_WIDTH-1:0]                out_mantissa,
  output logic                                     out_overflow,
  output logic [SRC_WIDTH-1:0]                     out_source
);

  logic [SRC_WIDTH-1:0]      ptr;
  logic [SRC_WIDTH-1:0]      grant_idx;
  logic [SRC_WIDTH-1:0]      ptr_next;
  logic [NUM_REQUESTERS-1:0] grant;
  logic                      has_grant;
  logic                      advance_s1;
  logic                      advance_s2;

  logic                      s1_valid;
  logic                      s1_sign;
  logic [EXPONENT_WIDTH-1:0] s1_exponent;
  logic [MANTISSA_WIDTH-1:0] s1_mantissa;
  logic [ROUNDING_BITS-1:0]  s1_rounding_bits;
  logic [SRC_WIDTH-1:0]      s1_src;

  logic [EXPONENT_WIDTH-1:0] rnd_exponent;
  logic [MANTISSA_WIDTH-1:0] rnd_mantissa;
  logic                      rnd_overflow;
  logic                      special;

  rr_arbiter #(.N(NUM_REQUESTERS)) u_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign advance_s2 = !out_valid || out_ready;
  assign advance_s1 = !s1_valid || advance_s2;
  assign has_grant  = |grant;
  assign req_ready  = (advance_s1 && !rst) ? grant : '0;
  assign ptr_next   = (grant_idx == SRC_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + SRC_WIDTH'(1);

  result_rounder #(
    .EXPONENT_WIDTH   (EXPONENT_WIDTH),
    .MANTISSA_WIDTH   (MANTISSA_WIDTH),
    .ROUND_TO_NEAREST (ROUND_TO_NEAREST),
    .ROUNDING_BITS    (ROUNDING_BITS)
  ) u_rounder (
    .exponent         (s1_exponent),
    .mantissa         (s1_mantissa),
    .rounding_bits    (s1_rounding_bits),
    .rounded_exponent (rnd_exponent),
    .rounded_mantissa (rnd_mantissa),
    .overflow         (rnd_overflow)
  );

  // Inf/NaN operands bypass rounding untouched
  assign special = &s1_exponent;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr              <= '0;
      s1_valid         <= 1'b0;
      s1_sign          <= 1'b0;
      s1_exponent      <= '0;
      s1_mantissa      <= '0;
      s1_rounding_bits <= '0;
      s1_src           <= '0;
      out_valid        <= 1'b0;
      out_sign         <= 1'b0;
      out_exponent     <= '0;
      out_mantissa     <= '0;
      out_overflow     <= 1'b0;
      out_source       <= '0;
    end else begin
      if (advance_s1) begin
        s1_valid <= has_grant;
        if (has_grant) begin
          ptr              <= ptr_next;
          s1_src           <= grant_idx;
          s1_sign          <= req_sign[grant_idx];
          s1_exponent      <= req_exponent[field_lsb(32'(grant_idx), EXPONENT_WIDTH) +: EXPONENT_WIDTH];
          s1_mantissa      <= req_mantissa[field_lsb(32'(grant_idx), MANTISSA_WIDTH) +: MANTISSA_WIDTH];
          s1_rounding_bits <= req_rounding_bits[field_lsb(32'(grant_idx), ROUNDING_BITS) +: ROUNDING_BITS];
        end
      end
      if (advance_s2) begin
        out_valid    <= s1_valid;
        out_sign     <= s1_sign;
        out_exponent <= special ? s1_exponent : rnd_exponent;
        out_mantissa <= special ? s1_mantissa : rnd_mantissa;
        out_overflow <= special ? 1'b0 : rnd_overflow;
        out_source   <= s1_src;
      end
    end
  end

endmodule

// File: tb/tb_round_scheduler.sv
// Directed bench for round_scheduler: a default N=2 instance and a truncating N=3 instance.
module tb_round_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst;
  // instance a: N=2, round to nearest
  logic [1:0]  a_req_valid, a_req_ready, a_req_sign;
  logic [15:0] a_req_exponent;
  logic [45:0] a_req_mantissa;
  logic [5:0]  a_req_rb;
  logic        a_out_valid, a_out_ready, a_out_sign, a_out_overflow;
  logic [7:0]  a_out_exponent;
  logic [22:0] a_out_mantissa;
  logic [0:0]  a_out_source;
  // instance b: N=3, truncate
  logic [2:0]  b_req_valid, b_req_ready, b_req_sign;
  logic [23:0] b_req_exponent;
  logic [68:0] b_req_mantissa;
  logic [8:0]  b_req_rb;
  logic        b_out_valid, b_out_ready, b_out_sign, b_out_overflow;
  logic [7:0]  b_out_exponent;
  logic [22:0] b_out_mantissa;
  logic [1:0]  b_out_source;

  round_scheduler dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_sign(a_req_sign),
    .req_exponent(a_req_exponent), .req_mantissa(a_req_mantissa), .req_rounding_bits(a_req_rb),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sign(a_out_sign),
    .out_exponent(a_out_exponent), .out_mantissa(a_out_mantissa),
    .out_overflow(a_out_overflow), .out_source(a_out_source)
  );

  round_scheduler #(.ROUND_TO_NEAREST(0), .NUM_REQUESTERS(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_sign(b_req_sign),
    .req_exponent(b_req_exponent), .req_mantissa(b_req_mantissa), .req_rounding_bits(b_req_rb),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sign(b_out_sign),
    .out_exponent(b_out_exponent), .out_mantissa(b_out_mantissa),
    .out_overflow(b_out_overflow), .out_source(b_out_source)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_a(input int i, input logic s, input logic [7:0] e, input logic [22:0] m,
                       input logic [2:0] rb);
    a_req_sign[i]          = s;
    a_req_exponent[i*8 +: 8]   = e;
    a_req_mantissa[i*23 +: 23] = m;
    a_req_rb[i*3 +: 3]         = rb;
  endtask

  task automatic set_b(input int i, input logic s, input logic [7:0] e, input logic [22:0] m,
                       input logic [2:0] rb);
    b_req_sign[i]          = s;
    b_req_exponent[i*8 +: 8]   = e;
    b_req_mantissa[i*23 +: 23] = m;
    b_req_rb[i*3 +: 3]         = rb;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a_req_valid = '0;
    b_req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    rst = 1'b1;
    a_req_valid = '0; a_req_sign = '0; a_req_exponent = '0; a_req_mantissa = '0; a_req_rb = '0;
    b_req_valid = '0; b_req_sign = '0; b_req_exponent = '0; b_req_mantissa = '0; b_req_rb = '0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    tick();
    tick();
    set_a(0, 1'b0, 8'h30, 23'h5, 3'b000);
    set_a(1, 1'b0, 8'h31, 23'h6, 3'b000);
    a_req_valid = 2'b11;
    settle();
    total++; if (a_req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", a_req_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    total++; if ({a_out_sign, a_out_exponent, a_out_mantissa, a_out_overflow, a_out_source} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h/%h/%b want all zero", a_out_exponent, a_out_mantissa, a_out_source);
    end
    // fill S1 and S2 from requester 0 only, leaving ptr at 1
    rst = 1'b0;
    a_req_valid = 2'b01;
    a_out_ready = 1'b0;
    tick();
    tick();
    settle();
    total++; if (a_out_valid !== 1'b1 || a_req_ready !== 2'b00) begin
      bad++; $display("FAIL fill_stall: got valid=%b ready=%b want 1/00", a_out_valid, a_req_ready);
    end
    rst = 1'b1;
    tick();
    total++; if (a_out_valid !== 1'b0 || a_req_ready !== 2'b00) begin
      bad++; $display("FAIL reset_mid_stream: got valid=%b ready=%b want 0/00", a_out_valid, a_req_ready);
    end
    rst = 1'b0;
    a_req_valid = 2'b11;
    a_out_ready = 1'b1;
    settle();
    total++; if (a_req_ready !== 2'b01) begin bad++; $display("FAIL reset_ptr: got %b want 01", a_req_ready); end
    tick();
    a_req_valid = 2'b00;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (a_out_valid) begin
        seen++;
        total++; if (a_out_source !== 1'b0 || a_out_exponent !== 8'h30) begin
          bad++; $display("FAIL post_reset_result: got src=%0d exp=%h want 0/30", a_out_source, a_out_exponent);
        end
      end
      tick();
    end
    total++; if (seen != 1) begin bad++; $display("FAIL post_reset_count: got %0d want 1", seen); end
  endtask

  task automatic test_single;
    set_a(0, 1'b0, 8'h80, 23'h000001, 3'b100);
    a_req_valid = 2'b01;
    a_out_ready = 1'b1;
    settle();
    total++; if (a_req_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", a_req_ready); end
    tick();
    a_req_valid = 2'b00;
    tick();
    total++; if (a_out_valid !== 1'b1 || a_out_exponent !== 8'h80 || a_out_mantissa !== 23'h000002 ||
                 a_out_overflow !== 1'b0 || a_out_source !== 1'b0 || a_out_sign !== 1'b0) begin
      bad++; $display("FAIL single_result: got v=%b exp=%h man=%h ovf=%b src=%0d want 1/80/000002/0/0",
                      a_out_valid, a_out_exponent, a_out_mantissa, a_out_overflow, a_out_source);
    end
    tick();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", a_out_valid); end
  endtask

  task automatic test_round_robin;
    logic [1:0] want_ready;
    logic [0:0] want_src;
    do_reset();
    a_out_ready = 1'b1;
    set_a(0, 1'b0, 8'h10, 23'h000100, 3'b000);
    set_a(1, 1'b1, 8'h20, 23'h000200, 3'b000);
    a_req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      settle();
      want_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (a_req_ready !== want_ready) begin
        bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, a_req_ready, want_ready);
      end
      if (k >= 2) begin
        want_src = 1'(k % 2);
        total++; if (a_out_valid !== 1'b1 || a_out_source !== want_src ||
                     a_out_exponent !== (want_src ? 8'h20 : 8'h10) || a_out_sign !== want_src) begin
          bad++; $display("FAIL rr_out[%0d]: got v=%b src=%0d exp=%h want 1/%0d", k, a_out_valid,
                          a_out_source, a_out_exponent, want_src);
        end
      end
      tick();
    end
    a_req_valid = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_overflow;
    a_out_ready = 1'b1;
    set_a(0, 1'b1, 8'hFE, 23'h7FFFFF, 3'b110);
    a_req_valid = 2'b01;
    tick();
    a_req_valid = 2'b00;
    tick();
    total++; if (a_out_valid !== 1'b1 || a_out_exponent !== 8'hFF || a_out_mantissa !== 23'h0 ||
                 a_out_overflow !== 1'b1 || a_out_sign !== 1'b1) begin
      bad++; $display("FAIL overflow: got v=%b exp=%h man=%h ovf=%b want 1/FF/000000/1",
                      a_out_valid, a_out_exponent, a_out_mantissa, a_out_overflow);
    end
    set_a(0, 1'b0, 8'hFF, 23'h400000, 3'b111);
    a_req_valid = 2'b01;
    tick();
    a_req_valid = 2'b00;
    tick();
    total++; if (a_out_valid !== 1'b1 || a_out_exponent !== 8'hFF || a_out_mantissa !== 23'h400000 ||
                 a_out_overflow !== 1'b0) begin
      bad++; $display("FAIL special_bypass: got v=%b exp=%h man=%h ovf=%b want 1/FF/400000/0",
                      a_out_valid, a_out_exponent, a_out_mantissa, a_out_overflow);
    end
    // exact tie on an even mantissa stays put
    set_a(0, 1'b0, 8'h7F, 23'h000002, 3'b100);
    a_req_valid = 2'b01;
    tick();
    a_req_valid = 2'b00;
    tick();
    total++; if (a_out_exponent !== 8'h7F || a_out_mantissa !== 23'h000002 || a_out_overflow !== 1'b0) begin
      bad++; $display("FAIL tie_even: got exp=%h man=%h ovf=%b want 7F/000002/0",
                      a_out_exponent, a_out_mantissa, a_out_overflow);
    end
    tick();
  endtask

  task automatic test_backpressure;
    int sent;
    int got;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      a_out_ready = !(cyc >= 2 && cyc <= 6);
      a_req_valid = (sent < 6) ? 2'b01 : 2'b00;
      set_a(0, 1'b0, 8'h40 + 8'(sent), 23'(sent), 3'b000);
      settle();
      if (cyc >= 2 && cyc <= 6) begin
        total++; if (a_req_ready !== 2'b00 || a_out_valid !== 1'b1 ||
                     a_out_mantissa !== 23'h0 || a_out_exponent !== 8'h40) begin
          bad++; $display("FAIL bp_stall[%0d]: got ready=%b v=%b exp=%h man=%h want 00/1/40/000000",
                          cyc, a_req_ready, a_out_valid, a_out_exponent, a_out_mantissa);
        end
      end
      if (a_out_valid && a_out_ready) begin
        total++; if (a_out_mantissa !== 23'(got) || a_out_exponent !== 8'h40 + 8'(got) || a_out_source !== 1'b0) begin
          bad++; $display("FAIL bp_order[%0d]: got exp=%h man=%h want %h/%h", got, a_out_exponent,
                          a_out_mantissa, 8'h40 + 8'(got), 23'(got));
        end
        got++;
      end
      if (a_req_valid[0] && a_req_ready[0]) sent++;
      tick();
    end
    total++; if (got != 6) begin bad++; $display("FAIL bp_count: got %0d want 6", got); end
    a_req_valid = 2'b00;
    a_out_ready = 1'b1;
    settle();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %b want 0", a_out_valid); end
  endtask

  task automatic test_truncate;
    logic [2:0] want_ready;
    int         src;
    do_reset();
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) set_b(i, 1'(i == 1), 8'h11 * 8'(i + 1), 23'h7FFFFF, 3'b111);
    b_req_valid = 3'b111;
    for (int k = 0; k < 9; k++) begin
      settle();
      want_ready = 3'b001 << (k % 3);
      total++; if (b_req_ready !== want_ready) begin
        bad++; $display("FAIL trunc_ready[%0d]: got %b want %b", k, b_req_ready, want_ready);
      end
      if (k >= 2) begin
        src = (k - 2) % 3;
        total++; if (b_out_valid !== 1'b1 || b_out_source !== 2'(src) || b_out_exponent !== 8'h11 * 8'(src + 1) ||
                     b_out_mantissa !== 23'h7FFFFF || b_out_overflow !== 1'b0 || b_out_sign !== 1'(src == 1)) begin
          bad++; $display("FAIL trunc_out[%0d]: got v=%b src=%0d exp=%h man=%h ovf=%b want 1/%0d/%h/7FFFFF/0",
                          k, b_out_valid, b_out_source, b_out_exponent, b_out_mantissa, b_out_overflow,
                          src, 8'h11 * 8'(src + 1));
        end
      end
      tick();
    end
    b_req_valid = 3'b000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_truncate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
